// File: rtl/data_ram_resp_pkg.sv
// Shared definitions for the data-memory responder: FSM state encodings,
// big-endian byte-lane masks, chip/write enable encodings and the lane
// legality helper used when DATA_RAM_ALIGN_CHECK_EN is defined.
package data_ram_resp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_WAIT = 2'b01;
  localparam state_t ST_DONE = 2'b10;

  // Lane masks: bit 3 is data[31:24], which is byte offset 0 (big-endian).
  localparam logic [3:0] SEL_B0 = 4'b1000;
  localparam logic [3:0] SEL_B1 = 4'b0100;
  localparam logic [3:0] SEL_B2 = 4'b0010;
  localparam logic [3:0] SEL_B3 = 4'b0001;
  localparam logic [3:0] SEL_H0 = 4'b1100;
  localparam logic [3:0] SEL_H1 = 4'b0011;
  localparam logic [3:0] SEL_W  = 4'b1111;

  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  // True when the lane pattern is legal for the byte offset. Full-word
  // reads at any offset are legal: the partial-word loads fetch the whole
  // word and extract their bytes themselves.
  function automatic logic sel_legal(input logic [1:0] off,
                                     input logic [3:0] sel,
                                     input logic       we);
    logic ok;
    ok = 1'b0;
    if ((we == WRITE_DISABLE) && (sel == SEL_W)) begin
      ok = 1'b1;
    end else begin
      case (off)
        2'b00:   ok = (sel == SEL_B0) || (sel == SEL_H0) || (sel == SEL_W);
        2'b01:   ok = (sel == SEL_B1);
        2'b10:   ok = (sel == SEL_B2) || (sel == SEL_H1);
        2'b11:   ok = (sel == SEL_B3);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/data_ram_resp_byte_bank.sv
// One byte lane of the data RAM: single-port 2^ADDR_W x 8 array with a
// write enable and a synchronous, enable-gated read register. The read
// register holds its value between enabled reads and clears on reset.
module data_ram_resp_byte_bank
  import data_ram_resp_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [2**ADDR_W];
  logic [7:0] rdata_q;
  logic [7:0] rdata_d;

  // Storage array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Capture a new byte only on an enabled read, otherwise hold.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en_i) begin
      rdata_d = mem_q[addr_i];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 8'h00;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram_resp.sv
// Data-memory responder for the MEM stage. Accepts one word/halfword/byte
// request, waits WAIT_CYCLES extra cycles, then acks for one cycle. Reads
// are captured into data_o on the edge entering DONE; writes commit on the
// edge leaving DONE. Dropping ce_i during WAIT aborts the access.
// Optional: define DATA_RAM_ALIGN_CHECK_EN to flag and suppress accesses
// whose lane pattern does not match the byte offset (align_err_o).
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        stallreq_o,
  output logic        align_err_o
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ack_q, ack_d;

  logic              enter_done_s;
  logic              eff_we_s;
  logic              rd_en_s;
  logic              commit_s;
  logic              err_block_s;
  logic [ADDR_W-1:0] bank_addr_s;
  logic [3:0]        bank_we_s;
  logic              unused_s;

  // Next-state, wait counter and request capture at acceptance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (ce_i == CHIP_ENABLE) begin
          we_d    = we_i;
          idx_d   = addr_i[ADDR_W+1:2];
          sel_d   = sel_i;
          wdata_d = data_i;
          cnt_d   = WAIT_LOAD;
          if (WAIT_LOAD == 4'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (ce_i == CHIP_DISABLE) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = ST_DONE;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // RAM control: read address comes straight from the bus while idle so a
  // zero-wait read can be captured on the acceptance edge.
  always_comb begin
    enter_done_s = (state_d == ST_DONE) && (state_q != ST_DONE);
    if (state_q == ST_IDLE) begin
      eff_we_s    = we_i;
      bank_addr_s = addr_i[ADDR_W+1:2];
    end else begin
      eff_we_s    = we_q;
      bank_addr_s = idx_q;
    end
    rd_en_s   = enter_done_s && (eff_we_s == WRITE_DISABLE);
    commit_s  = (state_q == ST_DONE) && (we_q == WRITE_ENABLE) && !err_block_s && !rst;
    bank_we_s = sel_q & {4{commit_s}};
    ack_d     = enter_done_s;
  end

`ifdef DATA_RAM_ALIGN_CHECK_EN
  logic [1:0] off_q, off_d;
  logic [1:0] eff_off_s;
  logic [3:0] eff_sel_s;
  logic       err_q, err_d;

  // Lane legality check on the effective request, flagged on entry to DONE.
  always_comb begin
    if (state_q == ST_IDLE) begin
      eff_off_s = addr_i[1:0];
      eff_sel_s = sel_i;
      off_d     = addr_i[1:0];
    end else begin
      eff_off_s = off_q;
      eff_sel_s = sel_q;
      off_d     = off_q;
    end
    err_d = enter_done_s && !sel_legal(eff_off_s, eff_sel_s, eff_we_s);
  end

  // Alignment state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      off_q <= 2'b00;
      err_q <= 1'b0;
    end else begin
      off_q <= off_d;
      err_q <= err_d;
    end
  end

  assign err_block_s = err_q;
  assign align_err_o = err_q;
`else
  assign err_block_s = 1'b0;
  assign align_err_o = 1'b0;
`endif

  // FSM, counter, captured request and ack registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      sel_q   <= 4'b0000;
      wdata_q <= 32'h0000_0000;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    data_ram_resp_byte_bank #(
      .ADDR_W(ADDR_W)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .we_i   (bank_we_s[g]),
      .rd_en_i(rd_en_s),
      .addr_i (bank_addr_s),
      .wdata_i(wdata_q[8*g +: 8]),
      .rdata_o(data_o[8*g +: 8])
    );
  end

  assign ack_o      = ack_q;
  assign stallreq_o = (ce_i == CHIP_ENABLE) && (state_q != ST_DONE);

  // Aliased upper address bits and the offset (used only by the check).
  assign unused_s = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

endmodule
